// File: rtl/multicycle_seq.sv
// -----------------------------------------------------------------------------
// multicycle_seq
//
// Multi-cycle sequencer for the single-issue MIPS datapath. Each instruction
// steps through FETCH, DECODE, EXEC, optionally MEM, and optionally WB. The
// static decoder outputs (RegWrite, MemRead, MemWrite, NPC source) are gated
// by the current state. This block also owns:
//   - the instruction and data memory request handshakes,
//   - a ready-timeout watchdog that parks the machine in ERR,
//   - a counter of retired instructions.
//
// Parameters
//   TIMEOUT_CYC  Number of cycles spent waiting on a ready before a bus error
//                (1 .. 2^TO_W-1).
//   TO_W         Width of the watchdog counter.
//   CNT_W        Width of the retired-instruction counter.
//
// Ports
//   clk_i             Rising-edge clock.
//   rst_ni            Synchronous reset, active low.
//   run_i             Start the next fetch; only looked at in IDLE.
//   imem_ready_i      Instruction memory data is valid this cycle.
//   dmem_ready_i      Data memory access completes this cycle.
//   dec_mem_read_i    Decoder MemRead for the instruction held in IR.
//   dec_mem_write_i   Decoder MemWrite.
//   dec_reg_write_i   Decoder RegWrite.
//   dec_npc_from_i    Decoder NPC source (00 PC+4, 01 branch, 10 jump).
//   imem_req_o        Instruction fetch request.
//   ir_we_o           Load the instruction register.
//   dmem_rd_o         Data memory read request.
//   dmem_wr_o         Data memory write request.
//   rf_we_o           Register-file write enable.
//   pc_we_o           PC update strobe; one pulse per retired instruction.
//   npc_sel_o         NPC source shown alongside pc_we_o (00 otherwise).
//   state_o           Current state: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4
//                     WB=5 ERR=7.
//   bus_err_o         Sticky timeout error flag.
//   instret_o         Retired-instruction count (wraps silently).
// -----------------------------------------------------------------------------
module multicycle_seq #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  input  logic             dec_mem_read_i,
  input  logic             dec_mem_write_i,
  input  logic             dec_reg_write_i,
  input  logic [1:0]       dec_npc_from_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             dmem_rd_o,
  output logic             dmem_wr_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic [1:0]       npc_sel_o,
  output logic [2:0]       state_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_e;

  localparam logic [TO_W-1:0] WDOG_LIMIT = TO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wdog_q, wdog_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] instret_q;

  logic isLoad;
  logic isStore;
  logic isMemOp;

  // When the decoder flags both a read and a write, the instruction is
  // handled purely as a load, so the store view masks out the read case.
  assign isLoad  = dec_mem_read_i;
  assign isStore = dec_mem_write_i & ~dec_mem_read_i;
  assign isMemOp = dec_mem_read_i | dec_mem_write_i;

  // Next-state and strobe decode. Strobes depend on the current state plus
  // the ready inputs, so they are combinational. The watchdog counts wait
  // cycles in FETCH and MEM. On the cycle the count hits the limit, a ready
  // still takes the normal path. Only a missing ready at that point moves the
  // machine into ERR. Any state change clears the watchdog, so the fetch
  // wait and the memory wait each get the full budget.
  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    bus_err_d  = bus_err_q;
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_rd_o  = 1'b0;
    dmem_wr_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    npc_sel_o  = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d   = S_ERR;
          bus_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (isMemOp) begin
          state_d = S_MEM;
        end else if (dec_reg_write_i) begin
          state_d = S_WB;
        end else begin
          pc_we_o   = 1'b1;
          npc_sel_o = dec_npc_from_i;
          state_d   = S_IDLE;
        end
      end
      S_MEM: begin
        dmem_rd_o = isLoad;
        dmem_wr_o = isStore;
        if (dmem_ready_i) begin
          if (isLoad) begin
            state_d = S_WB;
          end else begin
            pc_we_o = 1'b1;
            state_d = S_IDLE;
          end
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d   = S_ERR;
          bus_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we_o   = dec_reg_write_i;
        pc_we_o   = 1'b1;
        npc_sel_o = dec_npc_from_i;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        bus_err_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) wdog_d = '0;
  end

  // State, watchdog, error flag and retire counter. Reset takes priority
  // over everything, including an access still in flight. Because the
  // request strobes are decoded from state, they drop on the cycle after
  // reset. The retire counter advances on each PC update and wraps at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wdog_q    <= '0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_q + {{(CNT_W-1){1'b0}}, pc_we_o};
    end
  end

  assign state_o   = state_q;
  assign bus_err_o = bus_err_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// -----------------------------------------------------------------------------
// tb_multicycle_seq
//
// Self-checking bench for multicycle_seq. Each instruction is described by
// its decoder flags and by how many wait cycles each memory inserts. From
// that description, the bench builds the expected per-cycle sequence of
// states and strobes directly from the instruction-class timing rules:
//   - fetch,
//   - decode,
//   - execute,
//   - optional memory access,
//   - optional writeback.
// It then drives the DUT one cycle at a time and compares every output.
//
// The retire counter is instantiated 4 bits wide so that wrap-around can be
// exercised cheaply.
// -----------------------------------------------------------------------------
module tb_multicycle_seq;

  localparam int TIMEOUT = 64;
  localparam int CNTW    = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd7;

  logic            clk = 1'b0;
  logic            rstN;
  logic            runI;
  logic            imemReady;
  logic            dmemReady;
  logic            decMemRead;
  logic            decMemWrite;
  logic            decRegWrite;
  logic [1:0]      decNpcFrom;
  logic            imemReq;
  logic            irWe;
  logic            dmemRd;
  logic            dmemWr;
  logic            rfWe;
  logic            pcWe;
  logic [1:0]      npcSel;
  logic [2:0]      stateOut;
  logic            busErr;
  logic [CNTW-1:0] instret;

  int              checks = 0;
  int              errors = 0;
  logic [CNTW-1:0] expInstret;
  logic            expErr;

  multicycle_seq #(
    .TIMEOUT_CYC(TIMEOUT),
    .TO_W       (8),
    .CNT_W      (CNTW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .run_i          (runI),
    .imem_ready_i   (imemReady),
    .dmem_ready_i   (dmemReady),
    .dec_mem_read_i (decMemRead),
    .dec_mem_write_i(decMemWrite),
    .dec_reg_write_i(decRegWrite),
    .dec_npc_from_i (decNpcFrom),
    .imem_req_o     (imemReq),
    .ir_we_o        (irWe),
    .dmem_rd_o      (dmemRd),
    .dmem_wr_o      (dmemWr),
    .rf_we_o        (rfWe),
    .pc_we_o        (pcWe),
    .npc_sel_o      (npcSel),
    .state_o        (stateOut),
    .bus_err_o      (busErr),
    .instret_o      (instret)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Random single bit, used for inputs the DUT is supposed to ignore.
  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // One comparison: counts it, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and check every output at the falling edge.
  // Afterwards, step the reference retire count if a retire was expected.
  task automatic applyStimulus(input logic runV, input logic imemV,
                               input logic dmemV, input logic [2:0] eState,
                               input logic eImem, input logic eIr,
                               input logic eRd, input logic eWr,
                               input logic eRf, input logic ePc,
                               input logic [1:0] eNpc);
    runI      = runV;
    imemReady = imemV;
    dmemReady = dmemV;
    @(negedge clk);
    checkOutput("state",    32'(stateOut), 32'(eState));
    checkOutput("imem_req", 32'(imemReq),  32'(eImem));
    checkOutput("ir_we",    32'(irWe),     32'(eIr));
    checkOutput("dmem_rd",  32'(dmemRd),   32'(eRd));
    checkOutput("dmem_wr",  32'(dmemWr),   32'(eWr));
    checkOutput("rf_we",    32'(rfWe),     32'(eRf));
    checkOutput("pc_we",    32'(pcWe),     32'(ePc));
    checkOutput("npc_sel",  32'(npcSel),   32'(eNpc));
    checkOutput("bus_err",  32'(busErr),   32'(expErr));
    checkOutput("instret",  32'(instret),  32'(expInstret));
    @(posedge clk);
    #1;
    if (ePc) expInstret = expInstret + 1'b1;
  endtask

  // Synchronous reset for one cycle. Both readies are held high so that reset
  // is shown to win over a completing access.
  task automatic doReset();
    rstN      = 1'b0;
    runI      = rb();
    imemReady = 1'b1;
    dmemReady = 1'b1;
    @(posedge clk);
    #1;
    rstN       = 1'b1;
    expInstret = '0;
    expErr     = 1'b0;
  endtask

  // Walk one instruction through its expected cycle sequence.
  //   idleN    Number of IDLE cycles with run low before starting.
  //   fw, mwt  Fetch and memory wait counts. A value >= TIMEOUT means the
  //            ready never arrives, so the machine is expected to land in ERR.
  //   abortMem If >= 0, a reset is applied after that many memory wait cycles.
  task automatic runInstr(input logic mr, input logic mw, input logic rw,
                          input logic [1:0] npc, input int fw, input int mwt,
                          input int idleN, input int abortMem);
    logic isMem;
    logic execRetire;
    logic toWb;
    logic eWr;

    decMemRead  = mr;
    decMemWrite = mw;
    decRegWrite = rw;
    decNpcFrom  = npc;
    isMem       = mr | mw;
    execRetire  = !isMem && !rw;
    toWb        = isMem ? mr : rw;
    eWr         = mw & ~mr;

    for (int i = 0; i < idleN; i++)
      applyStimulus(1'b0, rb(), rb(), ST_IDLE, 0, 0, 0, 0, 0, 0, 2'b00);
    applyStimulus(1'b1, rb(), rb(), ST_IDLE, 0, 0, 0, 0, 0, 0, 2'b00);

    if (fw >= TIMEOUT) begin
      for (int i = 0; i < TIMEOUT; i++)
        applyStimulus(rb(), 1'b0, rb(), ST_FETCH, 1, 0, 0, 0, 0, 0, 2'b00);
      expErr = 1'b1;
      for (int i = 0; i < 5; i++)
        applyStimulus(rb(), rb(), rb(), ST_ERR, 0, 0, 0, 0, 0, 0, 2'b00);
      return;
    end
    for (int i = 0; i < fw; i++)
      applyStimulus(rb(), 1'b0, rb(), ST_FETCH, 1, 0, 0, 0, 0, 0, 2'b00);
    applyStimulus(rb(), 1'b1, rb(), ST_FETCH, 1, 1, 0, 0, 0, 0, 2'b00);

    applyStimulus(rb(), rb(), rb(), ST_DECODE, 0, 0, 0, 0, 0, 0, 2'b00);
    applyStimulus(rb(), rb(), rb(), ST_EXEC, 0, 0, 0, 0, 0, execRetire,
                  execRetire ? npc : 2'b00);

    if (isMem) begin
      if (mwt >= TIMEOUT) begin
        for (int i = 0; i < TIMEOUT; i++)
          applyStimulus(rb(), rb(), 1'b0, ST_MEM, 0, 0, mr, eWr, 0, 0, 2'b00);
        expErr = 1'b1;
        for (int i = 0; i < 5; i++)
          applyStimulus(rb(), rb(), rb(), ST_ERR, 0, 0, 0, 0, 0, 0, 2'b00);
        return;
      end
      for (int i = 0; i < mwt; i++) begin
        if (i == abortMem) begin
          doReset();
          return;
        end
        applyStimulus(rb(), rb(), 1'b0, ST_MEM, 0, 0, mr, eWr, 0, 0, 2'b00);
      end
      applyStimulus(rb(), rb(), 1'b1, ST_MEM, 0, 0, mr, eWr, 0, !mr, 2'b00);
    end

    if (toWb)
      applyStimulus(rb(), rb(), rb(), ST_WB, 0, 0, 0, 0, rw, 1, npc);
  endtask

  // Main sequence: directed instruction classes, then limit cases, random
  // traffic, reset during an access, counter wrap, and both timeout paths.
  initial begin
    rstN        = 1'b0;
    runI        = 1'b0;
    imemReady   = 1'b0;
    dmemReady   = 1'b0;
    decMemRead  = 1'b0;
    decMemWrite = 1'b0;
    decRegWrite = 1'b0;
    decNpcFrom  = 2'b00;
    expInstret  = '0;
    expErr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    // ADDU, LW with three waits, BEQ, SW, J, JAL, then read+write as a load.
    runInstr(1'b0, 1'b0, 1'b1, 2'b00, 0, 0, 1, -1);
    runInstr(1'b1, 1'b0, 1'b1, 2'b00, 0, 3, 1, -1);
    runInstr(1'b0, 1'b0, 1'b0, 2'b01, 0, 0, 0, -1);
    runInstr(1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 0, -1);
    runInstr(1'b0, 1'b0, 1'b0, 2'b10, 1, 0, 0, -1);
    runInstr(1'b0, 1'b0, 1'b1, 2'b10, 0, 0, 0, -1);
    runInstr(1'b1, 1'b1, 1'b1, 2'b00, 1, 1, 0, -1);

    // Ready arriving exactly at the watchdog limit, in both FETCH and MEM.
    runInstr(1'b1, 1'b0, 1'b1, 2'b00, TIMEOUT - 1, TIMEOUT - 1, 0, -1);
    runInstr(1'b0, 1'b1, 1'b0, 2'b00, TIMEOUT - 1, TIMEOUT - 1, 0, -1);

    // Randomized instruction mix.
    for (int n = 0; n < 40; n++)
      runInstr(rb(), rb(), rb(), 2'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)), -1);

    // Reset while a load is waiting on memory, then recover.
    runInstr(1'b1, 1'b0, 1'b1, 2'b00, 0, 5, 0, 2);
    runInstr(1'b0, 1'b0, 1'b1, 2'b00, 0, 0, 0, -1);

    // Seventeen back-to-back retires wrap the 4-bit counter to 1.
    doReset();
    for (int n = 0; n < 17; n++)
      runInstr(rb(), rb(), rb(), 2'($urandom_range(0, 2)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, -1);
    checkOutput("instret_wrap", 32'(instret), 32'd1);

    // Fetch timeout: ERR is sticky regardless of run; only reset clears it.
    runInstr(1'b0, 1'b0, 1'b1, 2'b00, TIMEOUT, 0, 0, -1);
    checkOutput("bus_err_sticky", 32'(busErr), 32'd1);
    doReset();
    runInstr(1'b0, 1'b0, 1'b1, 2'b00, 0, 0, 0, -1);

    // Data memory timeout on a store.
    runInstr(1'b0, 1'b1, 1'b0, 2'b00, 0, TIMEOUT, 0, -1);
    doReset();
    runInstr(1'b1, 1'b0, 1'b1, 2'b00, 0, 0, 0, -1);
    applyStimulus(1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, 0, 0, 0, 0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
